switch_dst_port_rx: RTL and testbench

- Destination-side receiver for one switch egress port. It consumes the switch's dst_addr/dst_data word stream through a valid/ready handshake.
- It filters words by destination address (own MAC or broadcast) and buffers accepted words in a small first-word-fall-through FIFO.
- It presents the buffered words to a downstream consumer.
- It keeps saturating counters of received and dropped words for the testbench scoreboard.

---
 rtl/switch_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/switch_dst_port_rx.sv | 102 ++++++++++
 tb/tb_switch_dst_port_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// switch_pkg : shared address/data/packet types for the switch egress path
// Rev 1.0
// ============================================================================
package switch_pkg;

   typedef logic [47:0] addr_t;
   typedef logic [31:0] data_t;

   typedef struct packed {
      addr_t addr;
      data_t data;
   } pkt_t;

   localparam addr_t BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

   function automatic logic addr_match(input addr_t addr, input addr_t own);
      return (addr == own) || (addr == BCAST_ADDR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : first-word-fall-through FIFO, head holds last popped word when empty
// Rev 1.0
// ============================================================================
module sync_fifo
   import switch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = pkt_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output T     head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   T                 mem_q [DEPTH];
   T                 last_q;
   T                 last_d;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [OCC_W-1:0] count_q;
   logic [OCC_W-1:0] count_d;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == OCC_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

   // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         last_d   = mem_q[rd_ptr_q];
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/switch_dst_port_rx.sv
`default_nettype none
// ============================================================================
// switch_dst_port_rx : egress receiver with MAC filter, FWFT buffer and stats
// Rev 1.0
// ============================================================================
module switch_dst_port_rx
   import switch_pkg::*;
#(
   parameter addr_t MY_ADDR = 48'h0000_0000_0001,
   parameter int    DEPTH   = 4,
   parameter int    CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [47:0]      dst_addr,
   input  logic [31:0]      dst_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [47:0]      out_addr,
   output logic [31:0]      out_data,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow
);

   logic             w_full;
   logic             w_empty;
   logic             w_in_xfer;
   logic             w_match;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   pkt_t             w_push_pkt;
   pkt_t             w_head;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [CNT_W-1:0] rx_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q;
   logic [CNT_W-1:0] drop_cnt_d;
   logic             overflow_q;
   logic             overflow_d;

   // Ready depends only on registered occupancy, never on the incoming word.
   assign in_ready  = !w_full;
   assign w_in_xfer = in_valid && in_ready && !reset;
   assign w_match   = addr_match(dst_addr, MY_ADDR);
   assign w_push    = w_in_xfer && w_match;
   assign w_drop    = w_in_xfer && !w_match;
   assign w_pop     = out_valid && out_ready && !reset;

   assign w_push_pkt.addr = dst_addr;
   assign w_push_pkt.data = dst_data;

   sync_fifo #(
      .DEPTH (DEPTH),
      .T     (pkt_t)
   ) u_fifo (
      .clk         (clk),
      .rst         (reset),
      .push_i      (w_push),
      .push_data_i (w_push_pkt),
      .pop_i       (w_pop),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .head_o      (w_head)
   );

   assign out_valid = !w_empty;
   assign out_addr  = w_head.addr;
   assign out_data  = w_head.data;

   always_comb begin
      rx_cnt_d   = rx_cnt_q;
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q | (w_push & w_full);
      if (w_push && (rx_cnt_q != '1)) begin
         rx_cnt_d = rx_cnt_q + 1'b1;
      end
      if (w_drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_cnt_q   <= '0;
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         rx_cnt_q   <= rx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign rx_count   = rx_cnt_q;
   assign drop_count = drop_cnt_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_dst_port_rx.sv
`default_nettype none
// ============================================================================
// tb_switch_dst_port_rx : directed + random checks against a queue-based model
// Rev 1.0
// ============================================================================
module tb_switch_dst_port_rx;
   import switch_pkg::*;

   localparam addr_t MY    = 48'h0000_0000_0001;
   localparam int    DEPTH = 4;
   localparam int    CNT_W = 5;
   localparam int    CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [47:0]      dst_addr;
   logic [31:0]      dst_data;
   logic             out_valid;
   logic             out_ready;
   logic [47:0]      out_addr;
   logic [31:0]      out_data;
   logic [CNT_W-1:0] rx_count;
   logic [CNT_W-1:0] drop_count;
   logic             overflow;

   switch_dst_port_rx #(
      .MY_ADDR (MY),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dst_addr   (dst_addr),
      .dst_data   (dst_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .rx_count   (rx_count),
      .drop_count (drop_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Reference: accepted words in a queue, last popped word, plain saturating ints.
   pkt_t mq[$];
   pkt_t m_last;
   int   m_rx;
   int   m_drop;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      pkt_t h;
      h = (mq.size() > 0) ? mq[0] : m_last;
      chk("in_ready",   in_ready,   (mq.size() < DEPTH));
      chk("out_valid",  out_valid,  (mq.size() > 0));
      chk("out_addr",   out_addr,   h.addr);
      chk("out_data",   out_data,   h.data);
      chk("rx_count",   rx_count,   m_rx);
      chk("drop_count", drop_count, m_drop);
      chk("overflow",   overflow,   1'b0);
   endtask

   task automatic tick();
      bit   in_x;
      bit   out_x;
      pkt_t p;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_last = '0;
         m_rx   = 0;
         m_drop = 0;
      end else begin
         in_x  = in_valid && (mq.size() < DEPTH);
         out_x = out_ready && (mq.size() > 0);
         if (out_x) m_last = mq.pop_front();
         if (in_x) begin
            if (dst_addr == MY || dst_addr == 48'hFFFF_FFFF_FFFF) begin
               p.addr = dst_addr;
               p.data = dst_data;
               mq.push_back(p);
               if (m_rx < CMAX) m_rx++;
            end else if (m_drop < CMAX) begin
               m_drop++;
            end
         end
      end
      @(negedge clk);
      compare();
   endtask

   task automatic drive(input logic v, input addr_t a, input data_t d, input logic r);
      in_valid  = v;
      dst_addr  = a;
      dst_data  = d;
      out_ready = r;
   endtask

   initial begin
      int    k;
      bit    acc;
      addr_t a;
      int    sel;

      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_addr",  out_addr,  48'h0);
      chk("rst_out_data",  out_data,  32'h0);
      chk("rst_rx",        rx_count,  0);

      // Own address accepted, visible the next cycle, then popped.
      drive(1'b1, MY, 32'hDEAD_BEEF, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_data",  out_data,  32'hDEAD_BEEF);
      drive(1'b0, '0, '0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      chk("t1_rx",    rx_count,   1);
      chk("t1_drop",  drop_count, 0);
      chk("t1_empty", out_valid,  1'b0);

      // Foreign address dropped; broadcast accepted.
      drive(1'b1, 48'h0000_0000_0002, 32'h1234, 1'b0);
      tick();
      chk("t2_novalid", out_valid,  1'b0);
      chk("t2_drop",    drop_count, 1);
      drive(1'b1, 48'hFFFF_FFFF_FFFF, 32'h5678, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0);
      chk("t2_bcast", out_data, 32'h5678);
      drive(1'b0, '0, '0, 1'b1);
      tick();

      // Fill to full with back-pressure, then release in order.
      k = 1;
      for (int c = 0; c < 30 && k <= 6; c++) begin
         if (c == 6) begin
            chk("t3_full_rdy", in_ready, 1'b0);
            chk("t3_head",     out_data, 32'd1);
            out_ready = 1'b1;
         end else if (c < 6) begin
            out_ready = 1'b0;
         end
         in_valid = 1'b1;
         dst_addr = MY;
         dst_data = k;
         acc = in_ready;
         tick();
         if (acc) k++;
      end
      chk("t3_sent", k, 7);
      drive(1'b0, '0, '0, 1'b1);
      for (int c = 0; c < 10 && out_valid; c++) tick();
      chk("t3_drained", out_valid, 1'b0);
      chk("t3_last",    out_data,  32'd6);

      // Steady push+pop at occupancy 2 across pointer wrap.
      drive(1'b1, MY, 32'h40, 1'b0);
      tick();
      drive(1'b1, MY, 32'h41, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, MY, 32'h42 + i, 1'b1);
         tick();
         chk("t4_rdy", in_ready,  1'b1);
         chk("t4_val", out_valid, 1'b1);
      end
      chk("t4_head", out_data, 32'h48);
      drive(1'b0, '0, '0, 1'b1);
      for (int c = 0; c < 10 && out_valid; c++) tick();

      // Reset mid-stream discards contents and the word offered during reset.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, MY, 32'h70 + i, 1'b0);
         tick();
      end
      reset = 1'b1;
      drive(1'b1, MY, 32'hBAD, 1'b0);
      tick();
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b1);
      chk("t5_valid", out_valid, 1'b0);
      chk("t5_rx",    rx_count,  0);
      chk("t5_rdy",   in_ready,  1'b1);
      tick();
      tick();
      chk("t5_still_empty", out_valid, 1'b0);

      // Saturation of both counters.
      for (int i = 0; i < CMAX + 3; i++) begin
         drive(1'b1, MY, 32'h100 + i, 1'b1);
         tick();
      end
      chk("t6_rx_sat", rx_count, CMAX);
      for (int i = 0; i < CMAX + 3; i++) begin
         drive(1'b1, 48'h0000_0000_0003, i, 1'b1);
         tick();
      end
      chk("t6_drop_sat", drop_count, CMAX);

      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0);
      tick();
      reset = 1'b0;

      // Random traffic with occasional reset.
      for (int i = 0; i < 800; i++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       a = MY;
            1:       a = 48'hFFFF_FFFF_FFFF;
            2:       a = 48'h0000_0000_0002;
            default: a = {16'($urandom), 32'($urandom)};
         endcase
         reset = ($urandom_range(0, 149) == 0);
         drive(($urandom_range(0, 3) != 0), a, 32'($urandom), ($urandom_range(0, 2) != 0));
         tick();
      end
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      tick();
      chk("end_overflow", overflow, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
